gray_in_decoder: RTL and testbench

- Input-side counterpart to the LED Gray-code display path: reads a BITS-wide Gray-coded word from external pins (switches, rotary/absolute encoder, or a looped-back LED bus) and converts it to binary.
- Synchronises and debounces the pins, converts the accepted Gray value to binary, and classifies each accepted change as step-up, step-down or skip error.
- Maintains a signed position accumulator.
- Sits directly behind the input pads, in the same single clock domain as the rest of the top level.

---
 rtl/gray_in_decoder.sv | 127 ++++++++++++
 tb/tb_gray_in_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_in_decoder.sv
// Gray-coded pin input: synchronise, debounce, decode to binary, classify each
// accepted change as up/down/skip and track a signed position. Optional sticky error flag under GRAY_DEC_STICKY_ERR_EN.
module gray_in_decoder #(
  parameter int BITS        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_LOG2 = 16,
  parameter int POS_W       = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [BITS-1:0]         gray_in,
`ifdef GRAY_DEC_STICKY_ERR_EN
  input  logic                    err_clr,
  output logic                    err_sticky,
`endif
  output logic [BITS-1:0]         bin_out,
  output logic                    valid,
  output logic                    step_up,
  output logic                    step_down,
  output logic                    skip_err,
  output logic signed [POS_W-1:0] position
);

  localparam logic [STABLE_LOG2-1:0] CNT_ONE = 1;
  localparam logic [BITS-1:0]        BIN_ONE = 1;
  localparam logic signed [POS_W-1:0] POS_ONE = 1;

  logic [BITS-1:0]        sync_r [SYNC_STAGES];
  logic [BITS-1:0]        sync_q;
  logic [BITS-1:0]        candidate;
  logic [BITS-1:0]        stable;
  logic [STABLE_LOG2-1:0] cnt;
  logic                   primed;
  logic                   cnt_sat;
  logic                   accept;
  logic [BITS-1:0]        dec;
  logic                   is_up;
  logic                   is_down;

  assign sync_q  = sync_r[SYNC_STAGES-1];
  assign cnt_sat = &cnt;
  // A saturated, unchanged value only re-accepts before the first baseline.
  assign accept  = cnt_sat && (sync_q == candidate) && ((candidate != stable) || !primed);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      candidate <= '0;
      cnt       <= '0;
    end else if (sync_q != candidate) begin
      candidate <= sync_q;
      cnt       <= '0;
    end else if (!cnt_sat) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Prefix XOR from the MSB down turns Gray into binary.
  always_comb begin
    logic acc;
    dec = '0;
    acc = 1'b0;
    for (int i = BITS - 1; i >= 0; i--) begin
      acc    = acc ^ candidate[i];
      dec[i] = acc;
    end
  end

  assign is_up   = (dec == bin_out + BIN_ONE);
  assign is_down = (dec == bin_out - BIN_ONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stable    <= '0;
      primed    <= 1'b0;
      bin_out   <= '0;
      valid     <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      skip_err  <= 1'b0;
      position  <= '0;
    end else begin
      valid     <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      skip_err  <= 1'b0;
      if (accept) begin
        stable  <= candidate;
        primed  <= 1'b1;
        bin_out <= dec;
        valid   <= 1'b1;
        if (primed) begin
          if (is_up) begin
            step_up  <= 1'b1;
            position <= position + POS_ONE;
          end else if (is_down) begin
            step_down <= 1'b1;
            position  <= position - POS_ONE;
          end else begin
            skip_err <= 1'b1;
          end
        end
      end
    end
  end

`ifdef GRAY_DEC_STICKY_ERR_EN
  logic skip_set;
  assign skip_set = accept && primed && !is_up && !is_down;

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!resetn)       err_sticky <= 1'b0;
    else if (skip_set) err_sticky <= 1'b1;
    else if (err_clr)  err_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_gray_in_decoder.sv
// Directed bench for gray_in_decoder with BITS=4, SYNC_STAGES=2, STABLE_LOG2=3, POS_W=8.
module tb_gray_in_decoder;

  logic              clk = 1'b0;
  logic              resetn;
  logic [3:0]        gray_in;
  logic [3:0]        bin_out;
  logic              valid, step_up, step_down, skip_err;
  logic signed [7:0] position;
`ifdef GRAY_DEC_STICKY_ERR_EN
  logic              err_clr;
  logic              err_sticky;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_in_decoder #(.BITS(4), .SYNC_STAGES(2), .STABLE_LOG2(3), .POS_W(8)) dut (
    .clk(clk),
    .resetn(resetn),
    .gray_in(gray_in),
`ifdef GRAY_DEC_STICKY_ERR_EN
    .err_clr(err_clr),
    .err_sticky(err_sticky),
`endif
    .bin_out(bin_out),
    .valid(valid),
    .step_up(step_up),
    .step_down(step_down),
    .skip_err(skip_err),
    .position(position)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Edges from the first one that samples the new pins until valid; -1 on timeout.
  task automatic wait_valid(input int budget, output int edges);
    edges = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic apply(input logic [3:0] g, output int edges);
    gray_in = g;
    wait_valid(40, edges);
  endtask

  task automatic baseline(input logic [3:0] g);
    int lat;
    gray_in = g;
    resetn  = 1'b0;
    step(3);
    resetn = 1'b1;
    wait_valid(40, lat);
    step(2);
  endtask

  task automatic test_reset;
    int lat;
    gray_in = 4'b0110;
    resetn  = 1'b0;
    step(3);
    checks++; if (valid !== 1'b0 || bin_out !== 4'd0 || position !== 8'sd0)
      begin errors++; $display("FAIL reset_outputs: valid=%b bin=%0d pos=%0d want 0/0/0", valid, bin_out, position); end
    checks++; if ({step_up, step_down, skip_err} !== 3'b000)
      begin errors++; $display("FAIL reset_flags: got %b want 000", {step_up, step_down, skip_err}); end
    resetn = 1'b1;
    wait_valid(40, lat);
    checks++; if (lat !== 11)
      begin errors++; $display("FAIL baseline_latency: got %0d edges want 11", lat); end
    checks++; if (bin_out !== 4'd4)
      begin errors++; $display("FAIL baseline_bin: got %0d want 4", bin_out); end
    checks++; if ({step_up, step_down, skip_err} !== 3'b000 || position !== 8'sd0)
      begin errors++; $display("FAIL baseline_flags: flags=%b pos=%0d want 000/0", {step_up, step_down, skip_err}, position); end
    step(1);
    checks++; if (valid !== 1'b0)
      begin errors++; $display("FAIL baseline_pulse_width: valid=%b want 0", valid); end
  endtask

  task automatic test_step_up;
    int lat;
    int extra;
    baseline(4'b0110);
    apply(4'b0111, lat);
    checks++; if (lat !== 11 || step_up !== 1'b1 || bin_out !== 4'd5 || position !== 8'sd1)
      begin errors++; $display("FAIL up_5: lat=%0d up=%b bin=%0d pos=%0d want 11/1/5/1", lat, step_up, bin_out, position); end
    extra = 0;
    for (int i = 0; i < 9; i++) begin step(1); if (valid) extra++; end
    checks++; if (extra !== 0)
      begin errors++; $display("FAIL no_reaccept: got %0d pulses want 0", extra); end
    apply(4'b0101, lat);
    checks++; if (lat !== 11 || step_up !== 1'b1 || step_down !== 1'b0 || skip_err !== 1'b0)
      begin errors++; $display("FAIL up_6_flags: lat=%0d flags=%b want 11/100", lat, {step_up, step_down, skip_err}); end
    step(1);
    checks++; if (bin_out !== 4'd6 || position !== 8'sd2 || step_up !== 1'b0)
      begin errors++; $display("FAIL up_6_hold: bin=%0d pos=%0d up=%b want 6/2/0", bin_out, position, step_up); end
  endtask

  task automatic test_wrap;
    int lat;
    baseline(4'b0000);
    apply(4'b1000, lat);
    checks++; if (step_down !== 1'b1 || bin_out !== 4'd15 || position !== 8'shFF)
      begin errors++; $display("FAIL wrap_down: down=%b bin=%0d pos=%h want 1/15/ff", step_down, bin_out, position); end
    step(3);
    apply(4'b0000, lat);
    checks++; if (step_up !== 1'b1 || bin_out !== 4'd0 || position !== 8'sd0)
      begin errors++; $display("FAIL wrap_up: up=%b bin=%0d pos=%0d want 1/0/0", step_up, bin_out, position); end
  endtask

  task automatic test_skip;
    int lat;
    baseline(4'b0110);
`ifdef GRAY_DEC_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    apply(4'b1101, lat);
    checks++; if (skip_err !== 1'b1 || step_up !== 1'b0 || step_down !== 1'b0 || bin_out !== 4'd9 || position !== 8'sd0)
      begin errors++; $display("FAIL skip_9: flags=%b bin=%0d pos=%0d want 001/9/0", {step_up, step_down, skip_err}, bin_out, position); end
`ifdef GRAY_DEC_STICKY_ERR_EN
    checks++; if (err_sticky !== 1'b1)
      begin errors++; $display("FAIL sticky_set: got %b want 1", err_sticky); end
    step(3);
    checks++; if (err_sticky !== 1'b1)
      begin errors++; $display("FAIL sticky_hold: got %b want 1", err_sticky); end
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    checks++; if (err_sticky !== 1'b0)
      begin errors++; $display("FAIL sticky_clear: got %b want 0", err_sticky); end
    // 9 -> 4 is a skip; clear is raised only on the accept edge.
    gray_in = 4'b0110;
    step(10);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    checks++; if (valid !== 1'b1 || skip_err !== 1'b1 || err_sticky !== 1'b1)
      begin errors++; $display("FAIL sticky_set_wins: valid=%b skip=%b sticky=%b want 1/1/1", valid, skip_err, err_sticky); end
    step(1);
    checks++; if (err_sticky !== 1'b1 || skip_err !== 1'b0)
      begin errors++; $display("FAIL sticky_after: sticky=%b skip=%b want 1/0", err_sticky, skip_err); end
`else
    apply(4'b0110, lat);
    checks++; if (skip_err !== 1'b1 || bin_out !== 4'd4 || position !== 8'sd0)
      begin errors++; $display("FAIL skip_4: skip=%b bin=%0d pos=%0d want 1/4/0", skip_err, bin_out, position); end
`endif
  endtask

  task automatic test_glitch;
    int lat;
    int pulses;
    baseline(4'b0110);
    pulses = 0;
    gray_in = 4'b0111;
    for (int i = 0; i < 5; i++) begin step(1); if (valid) pulses++; end
    gray_in = 4'b0110;
    for (int i = 0; i < 20; i++) begin step(1); if (valid) pulses++; end
    checks++; if (pulses !== 0 || bin_out !== 4'd4 || position !== 8'sd0)
      begin errors++; $display("FAIL glitch: pulses=%0d bin=%0d pos=%0d want 0/4/0", pulses, bin_out, position); end
    apply(4'b0111, lat);
    checks++; if (lat !== 11 || step_up !== 1'b1 || bin_out !== 4'd5)
      begin errors++; $display("FAIL glitch_accept: lat=%0d up=%b bin=%0d want 11/1/5", lat, step_up, bin_out); end
  endtask

  task automatic test_reset_mid;
    int lat;
    baseline(4'b0110);
    apply(4'b0111, lat);
    apply(4'b0101, lat);
    apply(4'b0100, lat);
    checks++; if (position !== 8'sd3 || bin_out !== 4'd7)
      begin errors++; $display("FAIL pre_reset: pos=%0d bin=%0d want 3/7", position, bin_out); end
    gray_in = 4'b1100;
    step(5);
    resetn = 1'b0; step(1); resetn = 1'b1;
    checks++; if (bin_out !== 4'd0 || position !== 8'sd0 || valid !== 1'b0 || {step_up, step_down, skip_err} !== 3'b000)
      begin errors++; $display("FAIL mid_reset: bin=%0d pos=%0d valid=%b flags=%b want 0", bin_out, position, valid, {step_up, step_down, skip_err}); end
    wait_valid(40, lat);
    checks++; if (lat !== 11 || bin_out !== 4'd8 || {step_up, step_down, skip_err} !== 3'b000 || position !== 8'sd0)
      begin errors++; $display("FAIL post_reset_baseline: lat=%0d bin=%0d flags=%b pos=%0d want 11/8/000/0", lat, bin_out, {step_up, step_down, skip_err}, position); end
  endtask

  initial begin
    resetn  = 1'b0;
    gray_in = 4'b0000;
`ifdef GRAY_DEC_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    @(negedge clk);
    test_reset;
    test_step_up;
    test_wrap;
    test_skip;
    test_glitch;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
